// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time loader for the core's instruction SRAM. It accepts a byte
//   stream made of a length byte L, then 4*(L+1) little-endian payload bytes,
//   then an XOR checksum of the payload. Each group of four bytes becomes one
//   32-bit word, which is written through the SRAM's single read/write port.
//   The core is held in reset until the image has been received and the
//   checksum has matched.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       one-cycle restart request (honoured in DONE / ERR only)
//   byte_valid  source presents a byte
//   byte_data   stream byte
//   byte_ready  loader accepts the byte this cycle
//   mem_csb     SRAM chip select, active-low
//   mem_web     SRAM write enable, active-low
//   mem_addr    SRAM word address
//   mem_din     SRAM write data
//   core_reset  high while the core must stay in reset
//   done        image loaded and checksum matched
//   error       checksum mismatch
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] word_idx_reg;
  logic [1:0]        byte_idx_reg;
  logic [7:0]        csum_reg;
  logic [31:0]       buf_reg;
  logic              ready_reg;
  logic              core_reset_reg;
  logic              done_reg;
  logic              error_reg;

  logic              xfer;
  logic              in_write;

  // ready_reg already tracks the accepting states; reset gates it so the
  // source never sees a handshake while the loader is being reset.
  assign byte_ready = ready_reg & ~reset;
  assign xfer       = byte_valid & ready_reg;

  // Memory side is decoded purely from registers, so nothing on byte_* can
  // reach mem_* within a cycle.
  assign in_write = (state_reg == ST_WRITE);
  assign mem_csb  = ~in_write;
  assign mem_web  = ~in_write;
  assign mem_addr = in_write ? word_idx_reg : '0;
  assign mem_din  = in_write ? buf_reg : 32'd0;

  assign core_reset = core_reset_reg;
  assign done       = done_reg;
  assign error      = error_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_LEN;
      len_reg        <= '0;
      word_idx_reg   <= '0;
      byte_idx_reg   <= 2'd0;
      csum_reg       <= 8'd0;
      buf_reg        <= 32'd0;
      ready_reg      <= 1'b1;
      core_reset_reg <= 1'b1;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_LEN: begin
          if (xfer) begin
            len_reg      <= ADDR_W'(byte_data);
            word_idx_reg <= '0;
            byte_idx_reg <= 2'd0;
            csum_reg     <= 8'd0;
            state_reg    <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (xfer) begin
            buf_reg[{byte_idx_reg, 3'b000} +: 8] <= byte_data;
            csum_reg <= csum_reg ^ byte_data;
            if (byte_idx_reg == 2'd3) begin
              // Drop ready one cycle ahead so the write cycle accepts nothing.
              ready_reg <= 1'b0;
              state_reg <= ST_WRITE;
            end else begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
        end

        ST_WRITE: begin
          byte_idx_reg <= 2'd0;
          ready_reg    <= 1'b1;
          // Comparing against L before incrementing means word_idx never
          // wraps, even for a full 2^ADDR_W-word image.
          if (word_idx_reg == len_reg) begin
            state_reg <= ST_CSUM;
          end else begin
            word_idx_reg <= word_idx_reg + ADDR_W'(1);
            state_reg    <= ST_DATA;
          end
        end

        ST_CSUM: begin
          if (xfer) begin
            ready_reg <= 1'b0;
            if (byte_data == csum_reg) begin
              state_reg      <= ST_DONE;
              done_reg       <= 1'b1;
              core_reset_reg <= 1'b0;
            end else begin
              state_reg <= ST_ERR;
              error_reg <= 1'b1;
            end
          end
        end

        ST_DONE, ST_ERR: begin
          if (start) begin
            state_reg      <= ST_LEN;
            ready_reg      <= 1'b1;
            core_reset_reg <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg      <= ST_LEN;
          ready_reg      <= 1'b1;
          core_reset_reg <= 1'b1;
          done_reg       <= 1'b0;
          error_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W = 8;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_csb;
  logic              mem_web;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              core_reset;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_csb    (mem_csb),
    .mem_web    (mem_web),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Record every SRAM write the loader presents.
  always @(negedge clk) begin
    if (mem_csb === 1'b0 && mem_web === 1'b0) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_din);
      $display("write addr %0d data 0x%08h", mem_addr, mem_din);
    end
  end

  // Reference stream: length byte, LSB-first payload, XOR of payload bytes.
  task automatic build_stream(input word_q_t words, input bit corrupt, output byte_q_t s);
    logic [7:0] x;
    logic [31:0] w;
    s = {};
    x = 8'd0;
    s.push_back(8'(words.size() - 1));
    foreach (words[i]) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        s.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    s.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  // Drive bytes with random valid gaps; edges counts clock edges from the
  // first accepted byte, stalls counts cycles with valid offered but not ready.
  task automatic send_bytes(input byte_q_t s, input int gap_pct, output int edges, output int stalls);
    int idx;
    int guard;
    bit started;
    logic v;
    logic r;
    idx = 0; guard = 0; started = 0; edges = 0; stalls = 0;
    while (idx < s.size() && guard < 20000) begin
      @(negedge clk);
      v = ($urandom_range(99) >= gap_pct);
      byte_valid = v;
      byte_data  = s[idx];
      r = byte_ready;
      if (started && v && !r) stalls++;
      @(posedge clk);
      if (v && r) begin
        started = 1;
        idx++;
      end
      if (started) edges++;
      guard++;
    end
    if (idx < s.size()) check_value("send_timeout", 32'(idx), 32'(s.size()));
    #1 byte_valid = 1'b0;
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    @(negedge clk);
    while (!(done || error) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) check_value("finish_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify_writes(input string tag, input word_q_t words);
    check_value({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(words.size()));
    foreach (words[i]) begin
      if (i < wr_addr_q.size()) begin
        check_value({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(i));
        check_value({tag, "_wr_data"}, wr_data_q[i], words[i]);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_value({tag, "_ready"}, 32'(byte_ready), 32'd1);
    check_value({tag, "_csb"}, 32'(mem_csb), 32'd1);
    check_value({tag, "_web"}, 32'(mem_web), 32'd1);
    check_value({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_value({tag, "_din"}, mem_din, 32'd0);
    check_value({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check_value({tag, "_done"}, 32'(done), 32'd0);
    check_value({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wr_addr_q = {};
    wr_data_q = {};
  endtask

  task automatic check_done(input string tag);
    check_value({tag, "_done"}, 32'(done), 32'd1);
    check_value({tag, "_error"}, 32'(error), 32'd0);
    check_value({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    check_value({tag, "_ready"}, 32'(byte_ready), 32'd0);
  endtask

  initial begin
    word_q_t words;
    byte_q_t s;
    byte_q_t part;
    int edges;
    int stalls;
    int n;

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check_value("reset_ready_low", 32'(byte_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    // Single word; stream must be 00,78,56,34,12,08.
    words = {32'h12345678};
    build_stream(words, 1'b0, s);
    check_value("single_csum_byte", 32'(s[5]), 32'h08);
    send_bytes(s, 0, edges, stalls);
    wait_finish();
    verify_writes("single", words);
    check_done("single");
    $display("single word: done=%0d error=%0d", done, error);

    // Three words with random valid gaps.
    pulse_start();
    check_reset_values("restart");
    words = {32'h00000013, 32'h00100093, 32'hFFF00113};
    build_stream(words, 1'b0, s);
    send_bytes(s, 40, edges, stalls);
    wait_finish();
    verify_writes("three", words);
    check_done("three");
    $display("three words: done=%0d error=%0d", done, error);

    // Bad checksum, then recover with a good stream.
    pulse_start();
    words = {32'h12345678};
    build_stream(words, 1'b1, s);
    check_value("bad_csum_byte", 32'(s[5]), 32'h09);
    send_bytes(s, 0, edges, stalls);
    wait_finish();
    check_value("bad_error", 32'(error), 32'd1);
    check_value("bad_done", 32'(done), 32'd0);
    check_value("bad_core_reset", 32'(core_reset), 32'd1);
    repeat (5) @(negedge clk);
    check_value("bad_wr_count", 32'(wr_addr_q.size()), 32'd1);
    check_value("bad_error_held", 32'(error), 32'd1);
    $display("bad checksum: done=%0d error=%0d", done, error);
    pulse_start();
    check_reset_values("err_restart");
    words = {$urandom()};
    build_stream(words, 1'b0, s);
    send_bytes(s, 30, edges, stalls);
    wait_finish();
    verify_writes("recover", words);
    check_done("recover");
    $display("recover: done=%0d error=%0d", done, error);

    // Full image: word i = i * 0x01010101.
    pulse_start();
    words = {};
    for (int i = 0; i < (1 << ADDR_W); i++) words.push_back(32'(i) * 32'h01010101);
    build_stream(words, 1'b0, s);
    send_bytes(s, 20, edges, stalls);
    wait_finish();
    verify_writes("full", words);
    if (wr_addr_q.size() > 0)
      check_value("full_last_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 32'((1 << ADDR_W) - 1));
    check_done("full");
    $display("full image: writes=%0d done=%0d", wr_addr_q.size(), done);

    // Reset after word 1 is written.
    pulse_start();
    words = {$urandom(), $urandom(), $urandom()};
    build_stream(words, 1'b0, s);
    part = {};
    for (int i = 0; i < 9; i++) part.push_back(s[i]);
    send_bytes(part, 25, edges, stalls);
    n = 0;
    while (wr_addr_q.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_value("midload_wr_count", 32'(wr_addr_q.size()), 32'd2);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_value("midload_ready_in_reset", 32'(byte_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midload");
    wr_addr_q = {};
    wr_data_q = {};
    words = {$urandom()};
    build_stream(words, 1'b0, s);
    send_bytes(s, 0, edges, stalls);
    wait_finish();
    verify_writes("after_reset", words);
    check_done("after_reset");
    $display("reset mid-load: done=%0d", done);

    // Source holds valid high: two write stalls, latency 1+5*2+1 edges.
    pulse_start();
    words = {$urandom(), $urandom()};
    build_stream(words, 1'b0, s);
    send_bytes(s, 0, edges, stalls);
    @(negedge clk);
    check_value("stall_cycles", 32'(stalls), 32'd2);
    check_value("stall_latency", 32'(edges), 32'd12);
    verify_writes("stall", words);
    check_done("stall");
    $display("stalled source: edges=%0d stalls=%0d done=%0d", edges, stalls, done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
